instruction_prefetch: RTL
=========================

INSTRUCTION_PREFETCH -- requirements
Module: instruction_prefetch

Interface
REQ-001 SHALL have parameter IWIDTH, default 32, instruction width.
REQ-002 SHALL have parameter AWIDTH_INSTR, default 32, instruction-memory address width.
REQ-003 SHALL have parameter PC_WIDTH, default 32, PC width (equal to AWIDTH_INSTR).
REQ-004 SHALL have parameter DEPTH, default 4, prefetch queue entries (power of 2, >=2).
REQ-005 SHALL have parameter RESET_PC, default 0, first fetch address.
REQ-006 SHALL have one clock; reset is synchronous and active-low. Ports: f_clk in 1, clock; f_rst in 1, synchronous active-low reset.
REQ-007 SHALL have port f_i_ce, in, 1, fetch enable.
REQ-008 SHALL have port f_o_syn, out, 1, memory request valid.
REQ-009 SHALL have port f_o_addr_instr, out, AWIDTH_INSTR, request address.
REQ-010 SHALL have port f_i_ack, in, 1, memory response valid.
REQ-011 SHALL have port f_i_instr, in, IWIDTH, response data, valid with f_i_ack.
REQ-012 SHALL have port f_change_pc, in, 1, redirect request.
REQ-013 SHALL have port f_alu_pc_value, in, PC_WIDTH, redirect target.
REQ-014 SHALL have port f_i_flush, in, 1, replay flush.
REQ-015 SHALL have port f_i_stall, in, 1, downstream not ready.
REQ-016 SHALL have port f_o_ce, out, 1, head instruction valid.
REQ-017 SHALL have port f_o_instr, out, IWIDTH, head instruction.
REQ-018 SHALL have port f_o_pc, out, PC_WIDTH, head instruction PC.
REQ-019 SHALL have port f_o_flush, out, 1, one-cycle pulse after any flush/redirect.
REQ-020 SHALL have port f_o_stall, out, 1, queue empty while f_i_ce=1 (fetch starved).
REQ-021 SHALL have port f_o_count, out, $clog2(DEPTH)+1, queue occupancy.

Function
REQ-022 SHALL run FSM states IDLE (no request), REQ (f_o_syn=1 awaiting ack), FULL (queue has no room).
REQ-023 SHALL move IDLE->REQ the cycle after f_i_ce=1 with room, where room means f_o_count<DEPTH, counting the cycle's pop.
REQ-024 SHALL keep f_o_syn and f_o_addr_instr stable in REQ until f_i_ack; one request outstanding max.
REQ-025 SHALL, on f_i_ack in REQ (not discarded), push {fetch_pc, f_i_instr}, advance fetch_pc by 4 (mod 2^PC_WIDTH), and continue: REQ if room and f_i_ce, FULL if no room, IDLE if f_i_ce=0.
REQ-026 SHALL leave FULL for REQ the cycle after a pop creates room.
REQ-027 SHALL drive f_o_ce=1 whenever the queue is non-empty, with f_o_instr/f_o_pc taken from the head entry; the pushed entry is visible 1 cycle after its ack.
REQ-028 SHALL pop the head on f_o_ce=1 and f_i_stall=0; simultaneous push and pop keeps the count unchanged.
REQ-029 SHALL, on f_change_pc=1: empty the queue, set fetch_pc=f_alu_pc_value, pulse f_o_flush next cycle.
REQ-030 SHALL, on f_i_flush=1 (without f_change_pc): empty the queue and rewind fetch_pc to the head PC, or to the in-flight request PC, or leave it unchanged, in that priority; pulse f_o_flush.
REQ-031 SHALL give f_change_pc precedence over f_i_flush when both are asserted.
REQ-032 SHALL, when redirect/flush occurs with a request outstanding, hold f_o_syn and address until ack, discard that response (no push), then issue at the new fetch_pc.
REQ-033 SHALL, when redirect/flush coincides with f_i_ack, discard the ack data.
REQ-034 SHALL, when f_i_ce=0, issue no new request, complete (push) any outstanding one, and keep the queue drainable.
REQ-035 SHALL ignore f_i_ack outside REQ.

Reset
REQ-036 SHALL, on f_rst=0 at f_clk edge: state IDLE, fetch_pc=RESET_PC, queue empty, discard flag 0, and all outputs 0 (f_o_addr_instr=RESET_PC), overriding any in-flight request.

Verification
REQ-037 SHALL cover streaming: f_i_ce=1, ack every REQ cycle, f_i_stall=0 -> f_o_pc sequence 0,4,8,12 with matching instructions, no gaps after fill.
REQ-038 SHALL cover back-pressure: DEPTH=4, f_i_stall=1 -> f_o_count reaches 4, f_o_syn=0; release -> fetch resumes at 0x10 one cycle after first pop.
REQ-039 SHALL cover redirect mid-request: request at 0x8 pending, f_change_pc=1 target 0x100 -> ack for 0x8 discarded, next request 0x100, f_o_flush pulses once.
REQ-040 SHALL cover replay flush: queue holds PCs 0x20,0x24, f_i_flush=1 -> queue empty, next request address 0x20.
REQ-041 SHALL cover simultaneous f_change_pc, f_i_flush and f_i_ack -> target from f_alu_pc_value, ack data dropped.
REQ-042 SHALL cover reset mid-request: f_rst=0 while f_o_syn=1 -> next cycle f_o_syn=0, f_o_count=0, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_prefetch.sv
// Instruction prefetch queue: issues sequential fetches and buffers {pc, instr} pairs for decode.
// Latency: a fetched word is at the queue head 1 cycle after its ack; requests issue back-to-back on ack.
// Backpressure: f_i_stall holds the head; the FULL state stops new requests until a pop frees a slot.
//
// Ports:
//   f_clk, f_rst                     clock, synchronous active-low reset
//   f_i_ce                           fetch enable
//   f_o_syn, f_o_addr_instr          memory request valid / address (held until f_i_ack)
//   f_i_ack, f_i_instr               memory response valid / data
//   f_change_pc, f_alu_pc_value      redirect request / target
//   f_i_flush                        replay flush (rewind to oldest unconsumed PC)
//   f_i_stall                        downstream not ready
//   f_o_ce, f_o_instr, f_o_pc        head entry valid / instruction / PC
//   f_o_flush                        one-cycle pulse after any flush or redirect
//   f_o_stall                        queue empty while fetch is enabled
//   f_o_count                        queue occupancy
module instruction_prefetch #(
  parameter int unsigned IWIDTH       = 32,
  parameter int unsigned AWIDTH_INSTR = 32,
  parameter int unsigned PC_WIDTH     = 32,
  parameter int unsigned DEPTH        = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                      f_clk,
  input  logic                      f_rst,
  input  logic                      f_i_ce,
  output logic                      f_o_syn,
  output logic [AWIDTH_INSTR-1:0]   f_o_addr_instr,
  input  logic                      f_i_ack,
  input  logic [IWIDTH-1:0]         f_i_instr,
  input  logic                      f_change_pc,
  input  logic [PC_WIDTH-1:0]       f_alu_pc_value,
  input  logic                      f_i_flush,
  input  logic                      f_i_stall,
  output logic                      f_o_ce,
  output logic [IWIDTH-1:0]         f_o_instr,
  output logic [PC_WIDTH-1:0]       f_o_pc,
  output logic                      f_o_flush,
  output logic                      f_o_stall,
  output logic [$clog2(DEPTH):0]    f_o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FULL = 2'd2
  } state_t;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [IWIDTH-1:0]   instr;
  } q_entry_t;

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_fetch_pc;
  logic [PC_WIDTH-1:0] r_req_addr;
  logic                r_discard;
  logic                r_flush;
  logic [PW-1:0]       r_rd_ptr;
  logic [PW-1:0]       r_wr_ptr;
  logic [CW-1:0]       r_count;
  q_entry_t            r_q [DEPTH];

  state_t              w_state_nxt;
  logic [PC_WIDTH-1:0] w_fetch_pc_nxt;
  logic [CW-1:0]       w_count_nxt;
  logic                w_discard_nxt;
  logic                w_req_load;
  logic                w_flush_any;
  logic                w_ack;
  logic                w_push;
  logic                w_pop;
  logic                w_room;
  logic                w_nonempty;
  q_entry_t            w_head;

  assign w_nonempty  = (r_count != '0);
  assign w_head      = r_q[r_rd_ptr];
  assign w_flush_any = f_change_pc | f_i_flush;
  assign w_ack       = (r_state == S_REQ) && f_i_ack;
  // A response is dropped if its request was overtaken by an earlier flush,
  // or if a flush lands in the same cycle as the ack.
  assign w_push      = w_ack && !r_discard && !w_flush_any;
  assign w_pop       = w_nonempty && !f_i_stall;

  always_comb begin
    w_count_nxt = r_count;
    if (w_flush_any) begin
      w_count_nxt = '0;
    end else begin
      w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Room is judged on the occupancy after this cycle's push and pop.
  assign w_room = (w_count_nxt < CW'(DEPTH));

  always_comb begin
    w_fetch_pc_nxt = r_fetch_pc;
    if (f_change_pc) begin
      w_fetch_pc_nxt = f_alu_pc_value;
    end else if (f_i_flush) begin
      // Replay from the oldest instruction not yet consumed.
      if (w_nonempty) begin
        w_fetch_pc_nxt = w_head.pc;
      end else if ((r_state == S_REQ) && !r_discard) begin
        w_fetch_pc_nxt = r_req_addr;
      end else begin
        w_fetch_pc_nxt = r_fetch_pc;
      end
    end else if (w_push) begin
      w_fetch_pc_nxt = r_fetch_pc + PC_WIDTH'(4);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_req_load    = 1'b0;
    w_discard_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (f_i_ce) begin
          if (w_room) begin
            w_state_nxt = S_REQ;
            w_req_load  = 1'b1;
          end else begin
            w_state_nxt = S_FULL;
          end
        end
      end
      S_REQ: begin
        if (f_i_ack) begin
          if (!f_i_ce) begin
            w_state_nxt = S_IDLE;
          end else if (w_room) begin
            w_state_nxt = S_REQ;
            w_req_load  = 1'b1;
          end else begin
            w_state_nxt = S_FULL;
          end
        end else begin
          // Address stays on the bus; remember to drop whatever comes back.
          w_discard_nxt = r_discard | w_flush_any;
        end
      end
      S_FULL: begin
        if (w_room) begin
          if (f_i_ce) begin
            w_state_nxt = S_REQ;
            w_req_load  = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge f_clk) begin
    if (!f_rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_discard  <= 1'b0;
      r_flush    <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_discard  <= w_discard_nxt;
      r_flush    <= w_flush_any;
      r_count    <= w_count_nxt;
      if (w_req_load) begin
        r_req_addr <= w_fetch_pc_nxt;
      end
      if (w_flush_any) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
      end
    end
  end

  // Queue storage needs no reset; occupancy gates everything read from it.
  always_ff @(posedge f_clk) begin
    if (w_push) begin
      r_q[r_wr_ptr] <= '{pc: r_fetch_pc, instr: f_i_instr};
    end
  end

  assign f_o_syn        = (r_state == S_REQ);
  assign f_o_addr_instr = AWIDTH_INSTR'(r_req_addr);
  assign f_o_ce         = w_nonempty;
  assign f_o_instr      = w_nonempty ? w_head.instr : '0;
  assign f_o_pc         = w_nonempty ? w_head.pc : '0;
  assign f_o_flush      = r_flush;
  assign f_o_stall      = f_i_ce && !w_nonempty;
  assign f_o_count      = r_count;

endmodule
